// File: rtl/idp_control_unit.sv
// idp_control_unit: multicycle control sequencer for the integer datapath.
// It fetches 16-bit instructions over a req/ack port, decodes them into
// datapath control fields and latches the datapath status flags.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   mem_req/mem_addr      fetch request, address (always PC)
//   mem_ack/mem_data      fetch complete, instruction word (valid with ack)
//   C, N, Z               live datapath ALU status flags
//   W_En, W_Adr, R_Adr,   register file write enable and addresses
//   S_Adr
//   S_Sel, DS             S-mux select (1 = DS) and immediate data
//   ALU_OP                ALU operation
//   flags                 latched {C,N,Z}
//   halted                high once a HALT instruction has executed
//
// state  | meaning
// IDLE   | one cycle after reset before the first fetch
// FETCH  | mem_req high, waiting for mem_ack; ack loads IR and bumps PC
// DECODE | IR stable, control fields settle
// EXEC   | W_En pulse, flag capture, branch PC update
// HALT   | terminal; only reset leaves it

module idp_control_unit #(
  parameter int         AW        = 8,
  parameter logic [3:0] PASS_S_OP = 4'b0000
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  input  logic          C,
  input  logic          N,
  input  logic          Z,
  output logic          W_En,
  output logic [2:0]    W_Adr,
  output logic [2:0]    R_Adr,
  output logic [2:0]    S_Adr,
  output logic          S_Sel,
  output logic [15:0]   DS,
  output logic [3:0]    ALU_OP,
  output logic [2:0]    flags,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [2:0]    r_flags;

  logic [1:0]    w_cls;
  logic          w_is_ldi;
  logic          w_is_halt;
  logic          w_writes;
  logic          w_br_taken;
  logic [AW-1:0] w_offset;

  assign w_cls     = r_ir[15:14];
  assign w_is_ldi  = (w_cls == 2'b11) && (r_ir[13:12] == 2'b10);
  assign w_is_halt = (w_cls == 2'b11) && (r_ir[13:12] == 2'b01);
  assign w_writes  = (w_cls == 2'b00) || (w_cls == 2'b01) || w_is_ldi;
  assign w_offset  = AW'($signed(r_ir[10:0]));

  // Branch conditions look at the latched flags, never the live inputs.
  always_comb begin
    w_br_taken = 1'b0;
    if (w_cls == 2'b10) begin
      case (r_ir[13:11])
        3'b000:  w_br_taken = 1'b1;
        3'b001:  w_br_taken = r_flags[0];
        3'b010:  w_br_taken = ~r_flags[0];
        3'b011:  w_br_taken = r_flags[1];
        3'b100:  w_br_taken = r_flags[2];
        default: w_br_taken = 1'b0;
      endcase
    end
  end

  // Field decode is purely from IR, independent of state.
  always_comb begin
    ALU_OP = 4'd0;
    W_Adr  = 3'd0;
    R_Adr  = 3'd0;
    S_Adr  = 3'd0;
    S_Sel  = 1'b0;
    DS     = 16'd0;
    case (w_cls)
      2'b00: begin
        ALU_OP = r_ir[13:10];
        W_Adr  = r_ir[9:7];
        R_Adr  = r_ir[6:4];
        S_Adr  = r_ir[3:1];
      end
      2'b01: begin
        ALU_OP = r_ir[13:10];
        W_Adr  = r_ir[9:7];
        R_Adr  = r_ir[6:4];
        S_Sel  = 1'b1;
        DS     = 16'($signed(r_ir[3:0]));
      end
      2'b11: begin
        if (w_is_ldi) begin
          ALU_OP = PASS_S_OP;
          W_Adr  = r_ir[11:9];
          S_Sel  = 1'b1;
          DS     = 16'($signed(r_ir[8:0]));
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    W_En         = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) w_next_state = S_DECODE;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        W_En         = w_writes;
        w_next_state = w_is_halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted       = 1'b1;
        w_next_state = S_HALT;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= 16'h0000;
      r_flags <= 3'b000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH && mem_ack) begin
        r_ir <= mem_data;
        r_pc <= r_pc + AW'(1);
      end
      if (r_state == S_EXEC) begin
        if (w_writes)   r_flags <= {C, N, Z};
        // Target is relative to the PC already incremented by the fetch.
        if (w_br_taken) r_pc <= r_pc + w_offset;
      end
    end
  end

  assign mem_addr = r_pc;
  assign flags    = r_flags;

endmodule
